// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter for the shared register-file write-back port.
// Optional WB_CONFLICT_CNT_EN adds a saturating count of cycles with competing requests.
module wb_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_is_fp,
  output logic                      W_write_enable,
  output logic                      W_write_enable_f,
  output logic [ADDR_W-1:0]         W_rd,
  output logic [DATA_W-1:0]         W_rd_data,
  output logic [2:0]                grant_id
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]               conflict_cnt
`endif
);
  logic [ADDR_W-1:0] rd_a [8];
  logic [DATA_W-1:0] dat_a [8];
  logic [7:0]        vld, fp;
  logic [2:0]        ptr_q, ptr_d, win, gid_q;
  logic [3:0]        j;
  logic              found, we_q, wef_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  // Pad requesters out to 8 so a 3-bit winner index always selects in range
  for (genvar i = 0; i < 8; i++) begin : g_unpack
    if (i < NUM_REQ) begin : g_on
      assign rd_a[i]  = req_rd[i*ADDR_W +: ADDR_W];
      assign dat_a[i] = req_data[i*DATA_W +: DATA_W];
      assign vld[i]   = req_valid[i];
      assign fp[i]    = req_is_fp[i];
    end else begin : g_off
      assign rd_a[i]  = '0;
      assign dat_a[i] = '0;
      assign vld[i]   = 1'b0;
      assign fp[i]    = 1'b0;
    end
  end
  // Descending scan so the last hit is the first valid requester at or after ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr_q} + 4'(k);
      j = (j >= 4'(NUM_REQ)) ? j - 4'(NUM_REQ) : j;
      if (vld[j[2:0]]) begin
        found = 1'b1;
        win   = j[2:0];
      end
    end
    ptr_d = found ? ((win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1) : ptr_q;
  end
  assign req_ready = (found && !rst) ? NUM_REQ'(1) << win : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      wef_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      gid_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= found & ~fp[win] & (rd_a[win] != '0);
      wef_q <= found & fp[win];
      if (found) begin
        rd_q   <= rd_a[win];
        data_q <= dat_a[win];
        gid_q  <= win;
      end
    end
  end
  assign W_write_enable   = we_q;
  assign W_write_enable_f = wef_q;
  assign W_rd             = rd_q;
  assign W_rd_data        = data_q;
  assign grant_id         = gid_q;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= rst ? 16'd0 : (($countones(req_valid) > 1) && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  assign conflict_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter against a queue-free
// behavioural model of the round-robin write-back rules.
module tb_wb_port_arbiter;
  localparam int N = 3;
  logic        clk = 0, rst = 1;
  logic [2:0]  req_valid = 0, req_ready, req_is_fp = 0;
  logic [14:0] req_rd = 0;
  logic [95:0] req_data = 0;
  logic        W_write_enable, W_write_enable_f;
  logic [4:0]  W_rd;
  logic [31:0] W_rd_data;
  logic [2:0]  grant_id;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif
  int total = 0, bad = 0;
  int m_ptr = 0;
  logic m_we = 0, m_wef = 0;
  logic [4:0] m_rd = 0;
  logic [31:0] m_data = 0;
  logic [2:0] m_gid = 0, exp_ready = 0;

  wb_port_arbiter #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .req_is_fp(req_is_fp),
    .W_write_enable(W_write_enable), .W_write_enable_f(W_write_enable_f),
    .W_rd(W_rd), .W_rd_data(W_rd_data), .grant_id(grant_id)
`ifdef WB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [2:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive(input logic [2:0] v, input logic [14:0] rd, input logic [95:0] d,
                       input logic [2:0] f, input logic r);
    int w;
    @(negedge clk);
    req_valid = v; req_rd = rd; req_data = d; req_is_fp = f; rst = r;
    w = pick(v, m_ptr);
    exp_ready = (r || w < 0) ? 3'b000 : 3'(1 << w);
    #1;
  endtask

  task automatic tick;
    int w;
    @(posedge clk);
    w = pick(req_valid, m_ptr);
    if (rst) begin
      m_ptr = 0; m_we = 0; m_wef = 0; m_rd = 0; m_data = 0; m_gid = 0;
    end else if (w >= 0) begin
      m_rd = req_rd[w*5 +: 5]; m_data = req_data[w*32 +: 32]; m_gid = 3'(w);
      m_we = !req_is_fp[w] && m_rd != 0; m_wef = req_is_fp[w];
      m_ptr = (w + 1) % N;
    end else begin
      m_we = 0; m_wef = 0;
    end
    #1;
  endtask

  task automatic do_reset;
    drive(3'b000, 0, 0, 0, 1'b1);
    tick;
  endtask

  task automatic test_reset;
    drive(3'b111, 15'h7FFF, {96{1'b1}}, 3'b000, 1'b1);
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    tick;
    total++;
    if ({W_write_enable, W_write_enable_f, W_rd, W_rd_data, grant_id} !== 42'd0) begin
      bad++; $display("FAIL reset_bus got=%b/%b/%h/%h/%0d exp=all zero", W_write_enable, W_write_enable_f, W_rd, W_rd_data, grant_id);
    end
  endtask

  task automatic test_single;
    do_reset;
    drive(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 3'b000, 1'b0);
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    tick;
    total++;
    if ({W_write_enable, W_write_enable_f, W_rd, W_rd_data, grant_id} !== {1'b1, 1'b0, 5'd7, 32'hDEADBEEF, 3'd1}) begin
      bad++; $display("FAIL single_bus got=%b/%b/%0d/%h/%0d exp=1/0/7/deadbeef/1", W_write_enable, W_write_enable_f, W_rd, W_rd_data, grant_id);
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    for (int c = 0; c < 6; c++) begin
      drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 3'b000, 1'b0);
      tick;
      total++;
      if (grant_id !== 3'(c % 3) || W_write_enable !== 1'b1 || W_rd !== 5'(c % 3 + 1)) begin
        bad++; $display("FAIL b2b_cycle%0d got=gid%0d/we%b/rd%0d exp=gid%0d/we1/rd%0d", c, grant_id, W_write_enable, W_rd, c % 3, c % 3 + 1);
      end
    end
  endtask

  task automatic test_fp_f0;
    drive(3'b100, 15'd0, {32'h3F800000, 64'd0}, 3'b100, 1'b0);
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL fp_ready got=%b exp=100", req_ready); end
    tick;
    total++;
    if ({W_write_enable, W_write_enable_f, W_rd, W_rd_data, grant_id} !== {1'b0, 1'b1, 5'd0, 32'h3F800000, 3'd2}) begin
      bad++; $display("FAIL fp_bus got=%b/%b/%0d/%h/%0d exp=0/1/0/3f800000/2", W_write_enable, W_write_enable_f, W_rd, W_rd_data, grant_id);
    end
  endtask

  task automatic test_x0;
    do_reset;
    drive(3'b001, 15'd0, {64'd0, 32'h1234}, 3'b000, 1'b0);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL x0_ready got=%b exp=001", req_ready); end
    tick;
    total++; if ({W_write_enable, W_write_enable_f} !== 2'b00) begin bad++; $display("FAIL x0_enables got=%b%b exp=00", W_write_enable, W_write_enable_f); end
    drive(3'b011, {5'd0, 5'd4, 5'd0}, 96'd0, 3'b000, 1'b0);
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL x0_ptr_advance got=%b exp=010", req_ready); end
    tick;
  endtask

  task automatic test_idle_hold;
    drive(3'b010, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h55AA, 32'd0}, 3'b000, 1'b0);
    tick;
    drive(3'b000, 15'h7FFF, {96{1'b1}}, 3'b111, 1'b0);
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL idle_ready got=%b exp=000", req_ready); end
    tick;
    total++;
    if ({W_write_enable, W_write_enable_f, W_rd, W_rd_data, grant_id} !== {1'b0, 1'b0, 5'd9, 32'h55AA, 3'd1}) begin
      bad++; $display("FAIL idle_hold got=%b/%b/%0d/%h/%0d exp=0/0/9/55aa/1", W_write_enable, W_write_enable_f, W_rd, W_rd_data, grant_id);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    drive(3'b101, {5'd6, 5'd0, 5'd3}, {32'h22, 32'd0, 32'h11}, 3'b000, 1'b0);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rmid_first got=%b exp=001", req_ready); end
    tick;
    drive(3'b101, {5'd6, 5'd0, 5'd3}, {32'h22, 32'd0, 32'h11}, 3'b000, 1'b1);
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rmid_ready_in_rst got=%b exp=000", req_ready); end
    tick;
    total++; if ({W_write_enable, W_write_enable_f} !== 2'b00) begin bad++; $display("FAIL rmid_enables got=%b%b exp=00", W_write_enable, W_write_enable_f); end
    drive(3'b101, {5'd6, 5'd0, 5'd3}, {32'h22, 32'd0, 32'h11}, 3'b000, 1'b0);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rmid_ptr0 got=%b exp=001", req_ready); end
    tick;
  endtask

  task automatic test_random;
    do_reset;
    for (int c = 0; c < 400; c++) begin
      drive(3'($urandom), 15'($urandom), {$urandom, $urandom, $urandom}, 3'($urandom), $urandom_range(0, 40) == 0);
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rand_ready c%0d got=%b exp=%b", c, req_ready, exp_ready); end
      tick;
      total++;
      if ({W_write_enable, W_write_enable_f, W_rd, W_rd_data, grant_id} !== {m_we, m_wef, m_rd, m_data, m_gid}) begin
        bad++; $display("FAIL rand_bus c%0d got=%b/%b/%0d/%h/%0d exp=%b/%b/%0d/%h/%0d", c, W_write_enable, W_write_enable_f,
                        W_rd, W_rd_data, grant_id, m_we, m_wef, m_rd, m_data, m_gid);
      end
      total++; if (W_write_enable && W_write_enable_f) begin bad++; $display("FAIL rand_both_en c%0d got=11 exp=not both", c); end
    end
  endtask

`ifdef WB_CONFLICT_CNT_EN
  task automatic test_conflict_cnt;
    do_reset;
    for (int c = 0; c < 5; c++) begin
      drive(3'b011, {5'd0, 5'd2, 5'd1}, 96'd0, 3'b000, 1'b0);
      tick;
    end
    drive(3'b000, 15'd0, 96'd0, 3'b000, 1'b0);
    tick;
    total++; if (conflict_cnt !== 16'd5) begin bad++; $display("FAIL conflict_cnt got=%0d exp=5", conflict_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_fp_f0;
    test_x0;
    test_idle_hold;
    test_reset_mid;
`ifdef WB_CONFLICT_CNT_EN
    test_conflict_cnt;
`endif
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
